multi_channel_replay_queue: RTL and testbench

Parametrised successor to the per-pipe replay queue. One queue serves NUM_CH issue channels (int/complex/mem/fp, or any subset). It records issued-op groups, ages them by a configurable delay, then replays them in order to the issue stages while honouring scheduler stall and flush. It sits between the record points (RegisterWrite/Execution/TagAccess stages) and all IssueStages, and emits one shared replay strobe.

---
 rtl/multi_channel_replay_queue_pkg.sv | 18 +
 rtl/multi_channel_replay_queue_fifo.sv | 87 ++++++++
 rtl/multi_channel_replay_queue.sv | 77 +++++++
 tb/tb_multi_channel_replay_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multi_channel_replay_queue_pkg.sv
// Shared sizing helpers for the multi-channel replay queue and its group FIFO.
package multi_channel_replay_queue_pkg;

    // Countdown holds values 0..REPLAY_DELAY-1; keep at least one bit.
    function automatic int countdown_width(input int delay);
        return (delay > 1) ? $clog2(delay) : 1;
    endfunction

    function automatic int index_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full queue (count == DEPTH) is distinguishable from empty.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/multi_channel_replay_queue_fifo.sv
// Circular group storage with head/tail pointers, occupancy count and a
// per-slot countdown that marks when each stored group may be replayed.
module replay_group_fifo
    import multi_channel_replay_queue_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 16,
    parameter int REPLAY_DELAY = 2,
    localparam int IW  = index_width(DEPTH),
    localparam int CW  = count_width(DEPTH),
    localparam int CDW = countdown_width(REPLAY_DELAY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [NUM_CH-1:0]            push_entry,
    input  logic [NUM_CH*DATA_WIDTH-1:0] push_data,
    output logic                         head_valid,
    output logic                         head_eligible,
    output logic [NUM_CH-1:0]            head_entry,
    output logic [NUM_CH*DATA_WIDTH-1:0] head_data,
    output logic                         full,
    output logic [CW-1:0]                count,
    output logic [CW-1:0]                count_next
);

    logic [NUM_CH-1:0]            slot_entry [DEPTH];
    logic [NUM_CH*DATA_WIDTH-1:0] slot_data  [DEPTH];
    logic [CDW-1:0]               slot_cd    [DEPTH];
    logic [IW-1:0]                head;
    logic [IW-1:0]                tail;
    logic                         wr;
    logic                         rd;

    function automatic logic [CDW-1:0] dec_sat(input logic [CDW-1:0] v);
        return (v == '0) ? v : v - CDW'(1);
    endfunction

    assign head_valid    = (count != '0);
    assign full          = (count == CW'(DEPTH));
    assign head_entry    = slot_entry[head];
    assign head_data     = slot_data[head];
    assign head_eligible = (slot_cd[head] == '0);

    // When full, head and tail alias; a same-cycle pop frees the slot being written.
    assign rd = pop & head_valid;
    assign wr = push & (~full | rd) & ~flush;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + CW'(wr) - CW'(rd);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr)
                tail <= tail + IW'(1);
            if (rd)
                head <= head + IW'(1);
            count <= count_next;
        end
    end

    // Payload and countdown storage; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr && tail == IW'(i)) begin
                slot_entry[i] <= push_entry;
                slot_data[i]  <= push_data;
                slot_cd[i]    <= CDW'(REPLAY_DELAY - 1);
            end else begin
                slot_cd[i]    <= dec_sat(slot_cd[i]);
            end
        end
    end

endmodule

// File: rtl/multi_channel_replay_queue.sv
// Multi-channel replay queue: records issued-op groups, ages them, and replays
// them in FIFO order to the issue stages subject to stall and flush.
module multi_channel_replay_queue
    import multi_channel_replay_queue_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int DEPTH          = 16,
    parameter int REPLAY_DELAY   = 2,
    parameter int ALMOST_FULL_TH = 4,
    localparam int CW = count_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [NUM_CH-1:0]            recordEntry,
    input  logic [NUM_CH*DATA_WIDTH-1:0] recordData,
    output logic                         replay,
    output logic [NUM_CH-1:0]            replayEntry,
    output logic [NUM_CH*DATA_WIDTH-1:0] replayData,
    output logic [CW-1:0]                count,
    output logic                         almostFull,
    output logic                         overflow
);

    logic                         any_record;
    logic                         pop;
    logic                         head_valid;
    logic                         head_eligible;
    logic                         full;
    logic [NUM_CH-1:0]            head_entry;
    logic [NUM_CH*DATA_WIDTH-1:0] head_data;
    logic [CW-1:0]                count_next;

    assign any_record = |recordEntry;
    assign pop        = head_valid & head_eligible & ~stall & ~flush;

    replay_group_fifo #(
        .NUM_CH      (NUM_CH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .REPLAY_DELAY(REPLAY_DELAY)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (any_record),
        .pop          (pop),
        .push_entry   (recordEntry),
        .push_data    (recordData),
        .head_valid   (head_valid),
        .head_eligible(head_eligible),
        .head_entry   (head_entry),
        .head_data    (head_data),
        .full         (full),
        .count        (count),
        .count_next   (count_next)
    );

    assign replay      = pop;
    assign replayEntry = pop ? head_entry : '0;
    assign replayData  = pop ? head_data  : '0;

    // Flags track the post-edge occupancy so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            almostFull <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            almostFull <= ((DEPTH - int'(count_next)) <= ALMOST_FULL_TH);
            if (any_record && full && !pop && !flush)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_channel_replay_queue.sv
// Randomized bench for multi_channel_replay_queue against a timestamped group-queue model.
module tb_multi_channel_replay_queue;

    localparam int NUM_CH         = 4;
    localparam int DATA_WIDTH     = 64;
    localparam int DEPTH          = 16;
    localparam int REPLAY_DELAY   = 2;
    localparam int ALMOST_FULL_TH = 4;
    localparam int DW             = NUM_CH * DATA_WIDTH;
    localparam int CW             = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              flush;
    logic [NUM_CH-1:0] recordEntry;
    logic [DW-1:0]     recordData;
    logic              replay;
    logic [NUM_CH-1:0] replayEntry;
    logic [DW-1:0]     replayData;
    logic [CW-1:0]     count;
    logic              almostFull;
    logic              overflow;

    multi_channel_replay_queue #(
        .NUM_CH        (NUM_CH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH),
        .REPLAY_DELAY  (REPLAY_DELAY),
        .ALMOST_FULL_TH(ALMOST_FULL_TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .recordEntry(recordEntry),
        .recordData (recordData),
        .replay     (replay),
        .replayEntry(replayEntry),
        .replayData (replayData),
        .count      (count),
        .almostFull (almostFull),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] ent;
        logic [DW-1:0]     data;
        int                birth;
    } grp_t;

    grp_t q[$];
    int   cyc;
    bit   m_ov;
    bit   m_af;
    int   n_vec;
    int   n_bad;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] rnd_ent();
        return NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
    endfunction

    task automatic step(input bit r, input bit s, input bit f, input logic [NUM_CH-1:0] e);
        logic [DW-1:0] d;
        bit            exp_rep;
        grp_t          g;
        @(negedge clk);
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = $urandom;
        rst         = r;
        stall       = s;
        flush       = f;
        recordEntry = e;
        recordData  = d;
        #1;
        exp_rep = (q.size() > 0) && (cyc >= q[0].birth + REPLAY_DELAY) && !s && !f;
        check("replay", DW'(replay), DW'(exp_rep));
        check("replayEntry", DW'(replayEntry), exp_rep ? DW'(q[0].ent) : '0);
        if (exp_rep)
            check("replayData", replayData, q[0].data);
        check("count", DW'(count), DW'(q.size()));
        check("almostFull", DW'(almostFull), DW'(m_af));
        check("overflow", DW'(overflow), DW'(m_ov));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ov = 1'b0;
            m_af = 1'b0;
        end else begin
            if (f) begin
                q.delete();
            end else begin
                if (exp_rep)
                    void'(q.pop_front());
                if (e != '0) begin
                    if (q.size() < DEPTH) begin
                        g.ent   = e;
                        g.data  = d;
                        g.birth = cyc;
                        q.push_back(g);
                    end else begin
                        m_ov = 1'b1;
                    end
                end
            end
            m_af = ((DEPTH - q.size()) <= ALMOST_FULL_TH);
        end
        cyc++;
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        cyc         = 0;
        m_ov        = 1'b0;
        m_af        = 1'b0;
        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        recordEntry = '0;
        recordData  = '0;
        repeat (2) @(posedge clk);

        // Single push on channel 0, observe delay-limited replay.
        repeat (5) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 4'b0001);
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);

        // Four groups pushed back to back with a stall window covering their eligibility.
        for (int i = 0; i < 4; i++) step(1'b0, i >= 2, 1'b0, rnd_ent());
        repeat (3) step(1'b0, 1'b1, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, 1'b0, '0);

        // Fill under stall, overflow, then push+pop while full, then drain.
        repeat (18) step(1'b0, 1'b1, 1'b0, rnd_ent());
        repeat (6) step(1'b0, 1'b0, 1'b0, rnd_ent());
        repeat (20) step(1'b0, 1'b0, 1'b0, '0);

        // Long stream with continuous draining to wrap the pointers.
        repeat (300) step(1'b0, ($urandom_range(0, 9) == 0), 1'b0,
                          ($urandom_range(0, 9) < 8) ? rnd_ent() : '0);

        // Flush with held groups and a same-cycle push.
        repeat (5) step(1'b0, 1'b1, 1'b0, rnd_ent());
        step(1'b0, 1'b0, 1'b1, rnd_ent());
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);

        // Overflow, replay in progress, then reset.
        repeat (17) step(1'b0, 1'b1, 1'b0, rnd_ent());
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, rnd_ent());
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);

        // Random mix of every control.
        repeat (1500) step(($urandom_range(0, 199) == 0),
                           ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 49) == 0),
                           ($urandom_range(0, 1) == 0) ? rnd_ent() : '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
